// File: rtl/instr_issue_seq_pkg.sv
// Shared definitions for the instruction issue path: opcodes, field positions, FSM states.
package instr_issue_seq_pkg;

  // Data path and field widths
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned INSTR_W    = 16;

  // Opcode map: 0..5 are register-register, 6..10 take a 4-bit immediate as operand A
  localparam logic [3:0] OP_R0  = 4'd0;
  localparam logic [3:0] OP_R1  = 4'd1;
  localparam logic [3:0] OP_R2  = 4'd2;
  localparam logic [3:0] OP_R3  = 4'd3;
  localparam logic [3:0] OP_R4  = 4'd4;
  localparam logic [3:0] OP_R5  = 4'd5;
  localparam logic [3:0] OP_I6  = 4'd6;
  localparam logic [3:0] OP_I7  = 4'd7;
  localparam logic [3:0] OP_I8  = 4'd8;
  localparam logic [3:0] OP_I9  = 4'd9;
  localparam logic [3:0] OP_I10 = 4'd10;

  localparam int unsigned LAST_OP = 10;

  // Instruction field bit positions
  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RC_MSB = 11;
  localparam int unsigned RC_LSB = 8;
  localparam int unsigned RA_MSB = 7;
  localparam int unsigned RA_LSB = 4;
  localparam int unsigned RB_MSB = 3;
  localparam int unsigned RB_LSB = 0;

  // Issue sequencer states
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StRead   = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4
  } state_e;

  // I-type opcodes replace operand A with the zero-extended immediate
  function automatic logic is_itype(input logic [3:0] op);
    return op >= OP_I6;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction field decoder: splits a 16-bit word into operand fields.
module instr_field_decode
  import instr_issue_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned LAST_OP    = 10
) (
  input  logic [15:0]           instr,
  output logic [3:0]            op,
  output logic [REG_ADDR_W-1:0] rc,
  output logic [REG_ADDR_W-1:0] ra,
  output logic [REG_ADDR_W-1:0] rb,
  output logic [DATA_W-1:0]     imm,
  output logic                  imm_sel,
  output logic                  legal
);

  logic [3:0] w_mid_field;

  assign w_mid_field = instr[RA_MSB:RA_LSB];

  // Field split; the middle nibble is either register A or the immediate
  always_comb begin
    op      = instr[OP_MSB:OP_LSB];
    rc      = REG_ADDR_W'(instr[RC_MSB:RC_LSB]);
    rb      = REG_ADDR_W'(instr[RB_MSB:RB_LSB]);
    legal   = (32'(op) <= LAST_OP);
    imm_sel = is_itype(op);
    ra      = '0;
    imm     = '0;
    if (imm_sel) begin
      imm = DATA_W'(w_mid_field);
    end else begin
      ra  = REG_ADDR_W'(w_mid_field);
    end
  end

endmodule

// File: rtl/instr_issue_seq.sv
// Instruction issue sequencer: accepts one word, then walks DECODE/READ/EXEC/WB.
module instr_issue_seq
  import instr_issue_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = instr_issue_seq_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = instr_issue_seq_pkg::REG_ADDR_W,
  parameter int unsigned LAST_OP    = instr_issue_seq_pkg::LAST_OP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  input  logic [15:0]           instr,
  output logic                  instr_ready,
  output logic [REG_ADDR_W-1:0] reg_a_addr,
  output logic [REG_ADDR_W-1:0] reg_b_addr,
  output logic [REG_ADDR_W-1:0] reg_c_addr,
  output logic [DATA_W-1:0]     imm,
  output logic                  imm_sel,
  output logic [3:0]            alu_op,
  input  logic [DATA_W-1:0]     alu_result,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_en,
  output logic                  done,
  output logic                  illegal
);

  state_e                r_state;
  logic [15:0]           r_instr;
  logic [REG_ADDR_W-1:0] r_reg_a_addr;
  logic [REG_ADDR_W-1:0] r_reg_b_addr;
  logic [REG_ADDR_W-1:0] r_reg_c_addr;
  logic [DATA_W-1:0]     r_imm;
  logic                  r_imm_sel;
  logic [3:0]            r_alu_op;
  logic [DATA_W-1:0]     r_wb_data;
  logic                  r_wb_en;
  logic                  r_done;
  logic                  r_illegal;

  logic [3:0]            w_op;
  logic [REG_ADDR_W-1:0] w_rc;
  logic [REG_ADDR_W-1:0] w_ra;
  logic [REG_ADDR_W-1:0] w_rb;
  logic [DATA_W-1:0]     w_imm;
  logic                  w_imm_sel;
  logic                  w_legal;

  // Decode always looks at the captured word, so a changing input bus is harmless
  instr_field_decode #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .LAST_OP    (LAST_OP)
  ) u_decode (
    .instr   (r_instr),
    .op      (w_op),
    .rc      (w_rc),
    .ra      (w_ra),
    .rb      (w_rb),
    .imm     (w_imm),
    .imm_sel (w_imm_sel),
    .legal   (w_legal)
  );

  // Sequencer FSM with registered decode, write-back and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_instr      <= '0;
      r_reg_a_addr <= '0;
      r_reg_b_addr <= '0;
      r_reg_c_addr <= '0;
      r_imm        <= '0;
      r_imm_sel    <= 1'b0;
      r_alu_op     <= '0;
      r_wb_data    <= '0;
      r_wb_en      <= 1'b0;
      r_done       <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_wb_en   <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= StDecode;
          end
        end
        StDecode: begin
          // Rejected words leave the previous operand outputs untouched
          if (w_legal) begin
            r_reg_a_addr <= w_ra;
            r_reg_b_addr <= w_rb;
            r_reg_c_addr <= w_rc;
            r_imm        <= w_imm;
            r_imm_sel    <= w_imm_sel;
            r_alu_op     <= w_op;
            r_state      <= StRead;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= StIdle;
          end
        end
        StRead: begin
          r_state <= StExec;
        end
        StExec: begin
          // Strobes are set here so they are high for exactly the WB cycle
          r_wb_data <= alu_result;
          r_wb_en   <= 1'b1;
          r_done    <= 1'b1;
          r_state   <= StWb;
        end
        StWb: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign instr_ready = (r_state == StIdle);
  assign reg_a_addr  = r_reg_a_addr;
  assign reg_b_addr  = r_reg_b_addr;
  assign reg_c_addr  = r_reg_c_addr;
  assign imm         = r_imm;
  assign imm_sel     = r_imm_sel;
  assign alu_op      = r_alu_op;
  assign wb_data     = r_wb_data;
  assign wb_en       = r_wb_en;
  assign done        = r_done;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_instr_issue_seq.sv
// Directed bench for instr_issue_seq; inputs change and outputs are sampled 1ns after posedge.
module tb_instr_issue_seq;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  reg_a_addr;
  logic [3:0]  reg_b_addr;
  logic [3:0]  reg_c_addr;
  logic [15:0] imm;
  logic        imm_sel;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic [15:0] wb_data;
  logic        wb_en;
  logic        done;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  instr_issue_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .reg_a_addr  (reg_a_addr),
    .reg_b_addr  (reg_b_addr),
    .reg_c_addr  (reg_c_addr),
    .imm         (imm),
    .imm_sel     (imm_sel),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .wb_data     (wb_data),
    .wb_en       (wb_en),
    .done        (done),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    int dones;
    logic [3:0] rc_log [3];

    rst_n       = 1'b0;
    instr_valid = 1'b1;
    instr       = 16'h0312;
    alu_result  = 16'h0000;

    // Reset held two edges with valid asserted: nothing is accepted
    step();
    step();
    chk("rst_wb_en", {15'b0, wb_en}, 16'h0);
    chk("rst_done", {15'b0, done}, 16'h0);
    chk("rst_illegal", {15'b0, illegal}, 16'h0);
    chk("rst_addr", {4'h0, reg_a_addr, reg_b_addr, reg_c_addr}, 16'h0);
    chk("rst_imm", imm, 16'h0);
    chk("rst_imm_sel_op", {11'b0, imm_sel, alu_op}, 16'h0);
    chk("rst_wb_data", wb_data, 16'h0);
    instr_valid = 1'b0;
    rst_n       = 1'b1;
    step();
    chk("rst_ready", {15'b0, instr_ready}, 16'h1);

    // R-type 0312: accept, then outputs at +1, wb at +3
    instr       = 16'h0312;
    instr_valid = 1'b1;
    alu_result  = 16'h00AB;
    step();
    chk("r_busy", {15'b0, instr_ready}, 16'h0);
    instr_valid = 1'b0;
    step();
    chk("r_reg_a", {12'b0, reg_a_addr}, 16'h1);
    chk("r_reg_b", {12'b0, reg_b_addr}, 16'h2);
    chk("r_reg_c", {12'b0, reg_c_addr}, 16'h3);
    chk("r_imm_sel", {15'b0, imm_sel}, 16'h0);
    chk("r_alu_op", {12'b0, alu_op}, 16'h0);
    chk("r_wb_early1", {15'b0, wb_en}, 16'h0);
    step();
    chk("r_wb_early2", {15'b0, wb_en}, 16'h0);
    step();
    chk("r_wb_en", {15'b0, wb_en}, 16'h1);
    chk("r_done", {15'b0, done}, 16'h1);
    chk("r_wb_data", wb_data, 16'h00AB);
    step();
    chk("r_wb_end", {14'b0, wb_en, done}, 16'h0);
    chk("r_ready_again", {15'b0, instr_ready}, 16'h1);
    chk("r_hold_c", {12'b0, reg_c_addr}, 16'h3);

    // I-type 7A59
    instr       = 16'h7A59;
    instr_valid = 1'b1;
    alu_result  = 16'h1234;
    step();
    instr_valid = 1'b0;
    step();
    chk("i_imm", imm, 16'h0005);
    chk("i_imm_sel", {15'b0, imm_sel}, 16'h1);
    chk("i_reg_a", {12'b0, reg_a_addr}, 16'h0);
    chk("i_reg_b", {12'b0, reg_b_addr}, 16'h9);
    chk("i_reg_c", {12'b0, reg_c_addr}, 16'hA);
    chk("i_alu_op", {12'b0, alu_op}, 16'h7);
    pulses = (wb_en === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (wb_en === 1'b1) pulses++;
      if (i == 1) chk("i_wb_data", wb_data, 16'h1234);
    end
    chk("i_wb_pulses", 16'(pulses), 16'd1);

    // Illegal opcode B
    instr       = 16'hB123;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    chk("ill_pulse", {15'b0, illegal}, 16'h1);
    chk("ill_ready", {15'b0, instr_ready}, 16'h1);
    pulses = (wb_en === 1'b1 || done === 1'b1) ? 1 : 0;
    step();
    chk("ill_pulse_end", {15'b0, illegal}, 16'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (wb_en === 1'b1 || done === 1'b1) pulses++;
    end
    chk("ill_no_wb", 16'(pulses), 16'd0);

    // Back-to-back, input word changes every cycle; rc field carries the step index
    dones       = 0;
    instr_valid = 1'b1;
    instr       = 16'h1045;
    for (int k = 0; k < 15; k++) begin
      step();
      if (done === 1'b1) begin
        if (dones < 3) rc_log[dones] = reg_c_addr;
        dones++;
      end
      instr = {4'h1, 4'(k + 1), 8'h45};
    end
    instr_valid = 1'b0;
    chk("b2b_done_cnt", 16'(dones), 16'd3);
    chk("b2b_rc0", {12'b0, rc_log[0]}, 16'h0);
    chk("b2b_rc1", {12'b0, rc_log[1]}, 16'h5);
    chk("b2b_rc2", {12'b0, rc_log[2]}, 16'hA);
    step();

    // Reset while in EXEC aborts without write-back
    instr       = 16'h0312;
    instr_valid = 1'b1;
    alu_result  = 16'h00EE;
    step();
    instr_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rx_wb_en", {15'b0, wb_en}, 16'h0);
    chk("rx_ready", {15'b0, instr_ready}, 16'h1);
    chk("rx_reg_c", {12'b0, reg_c_addr}, 16'h0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wb_en === 1'b1) pulses++;
    end
    chk("rx_no_wb", 16'(pulses), 16'd0);

    instr       = 16'h0312;
    instr_valid = 1'b1;
    alu_result  = 16'h00CD;
    step();
    instr_valid = 1'b0;
    step();
    chk("rx2_reg_c", {12'b0, reg_c_addr}, 16'h3);
    step();
    step();
    chk("rx2_wb_en", {15'b0, wb_en}, 16'h1);
    chk("rx2_wb_data", wb_data, 16'h00CD);
    step();
    chk("rx2_idle", {15'b0, instr_ready}, 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
